button_avalon_poller: RTL and testbench

Avalon-MM initiator that periodically polls the button controller's status register, detects button-state changes, echoes each new state to the LED register, and presents change events on a valid/ready stream. It sits between the Avalon-MM button slave and fabric logic that consumes button events without driving bus cycles itself.

---
 rtl/button_avalon_poller.sv | 173 +++++++++++++++++
 tb/tb_button_avalon_poller.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_avalon_poller.sv
// Avalon-MM initiator: polls the button status register, echoes changes to the LED register,
// and emits change events through a 1-deep valid/ready register (a full register drops new events).
module button_avalon_poller #(
  parameter int unsigned POLL_CYCLES    = 50000,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic        RD_ADDR        = 1'b0,
  parameter logic        WR_ADDR        = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic        avm_chipselect,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [7:0]  evt_state,
  output logic [7:0]  evt_changed,
  output logic        overflow,
  output logic        bus_error,
  input  logic        clear_flags
);

  localparam int unsigned PW = $clog2(POLL_CYCLES);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_COMPARE,
    S_WRITE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_timer;
  logic [TW-1:0] r_to_cnt;
  logic [7:0]    r_captured;
  logic [7:0]    r_last_state;
  logic          w_tick;
  logic          w_busy;
  logic          w_to_expired;
  logic          w_capture;
  logic          w_abort;
  logic          w_changed;
  logic          w_load;
  logic          w_xfer;
  logic          w_unused_rd;

  assign w_unused_rd  = ^avm_readdata[31:8];
  assign w_tick       = enable && (r_timer == '0);
  assign w_busy       = (r_state == S_READ) || (r_state == S_WRITE);
  assign w_to_expired = (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_changed    = (r_captured != r_last_state);
  assign w_load       = (r_state == S_COMPARE) && w_changed;
  assign w_xfer       = evt_valid && evt_ready;

  // Free-running poll timer; ticks that land outside IDLE are simply lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= PW'(POLL_CYCLES - 1);
    end else if (!enable || w_tick) begin
      r_timer <= PW'(POLL_CYCLES - 1);
    end else begin
      r_timer <= r_timer - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_capture      = 1'b0;
    w_abort        = 1'b0;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_chipselect = 1'b0;
    avm_address    = 1'b0;
    avm_writedata  = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (w_tick) w_state_nxt = S_READ;
      end
      S_READ: begin
        avm_read       = 1'b1;
        avm_chipselect = 1'b1;
        avm_address    = RD_ADDR;
        if (!avm_waitrequest) begin
          w_capture   = 1'b1;
          w_state_nxt = S_COMPARE;
        end else if (w_to_expired) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_COMPARE: begin
        w_state_nxt = w_changed ? S_WRITE : S_IDLE;
      end
      S_WRITE: begin
        avm_write      = 1'b1;
        avm_chipselect = 1'b1;
        avm_address    = WR_ADDR;
        avm_writedata  = {24'd0, r_last_state};
        if (!avm_waitrequest) begin
          w_state_nxt = S_IDLE;
        end else if (w_to_expired) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Counts stalled request cycles; restarts whenever a new request begins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (w_busy && avm_waitrequest) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end else begin
      r_to_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_captured   <= 8'd0;
      r_last_state <= 8'd0;
    end else begin
      if (w_capture) r_captured <= avm_readdata[7:0];
      if (w_load) r_last_state <= r_captured;
    end
  end

  // A load that coincides with a transfer replaces the register without overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid   <= 1'b0;
      evt_state   <= 8'd0;
      evt_changed <= 8'd0;
    end else if (w_load && !(evt_valid && !evt_ready)) begin
      evt_valid   <= 1'b1;
      evt_state   <= r_captured;
      evt_changed <= r_captured ^ r_last_state;
    end else if (w_xfer) begin
      evt_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      if (w_load && evt_valid && !evt_ready) overflow <= 1'b1;
      else if (clear_flags) overflow <= 1'b0;
      if (w_abort) bus_error <= 1'b1;
      else if (clear_flags) bus_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_button_avalon_poller.sv
// Directed bench for button_avalon_poller: table of poll transactions plus hand-written
// sequences for timeout, enable drop and reset during a stalled write.
module tb_button_avalon_poller;

  localparam int POLL = 8;
  localparam int TMO  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        avm_address, avm_read, avm_write, avm_chipselect;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'd0;
  logic        avm_waitrequest = 1'b0;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [7:0]  evt_state, evt_changed;
  logic        overflow, bus_error;
  logic        clear_flags = 1'b0;

  button_avalon_poller #(
    .POLL_CYCLES(POLL), .TIMEOUT_CYCLES(TMO), .RD_ADDR(1'b0), .WR_ADDR(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_chipselect(avm_chipselect), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_state(evt_state),
    .evt_changed(evt_changed), .overflow(overflow), .bus_error(bus_error),
    .clear_flags(clear_flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] rd;
    int         waits;
    logic       ready;
    logic       exp_wr;
    logic [7:0] exp_state;
    logic [7:0] exp_changed;
    logic       exp_vld;
    logic       exp_ovf;
    int         period;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int last_start = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_read(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (avm_read) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL read_start: no avm_read within 40 cycles");
    end
  endtask

  task automatic do_poll(input vec_t v, input string tag);
    bit ok;
    int rdc;
    bit stable;
    evt_ready = v.ready;
    wait_read(ok);
    if (!ok) return;
    if (v.period != 0) chk({tag, "_period"}, cyc - last_start, v.period);
    last_start = cyc;
    avm_readdata = {24'hA5C3E1, v.rd};
    rdc = 0;
    stable = 1'b1;
    while (avm_read && rdc < 20) begin
      if (avm_address !== 1'b0 || avm_chipselect !== 1'b1 || avm_write !== 1'b0) stable = 1'b0;
      avm_waitrequest = (rdc < v.waits);
      rdc++;
      @(negedge clk);
    end
    avm_waitrequest = 1'b0;
    chk({tag, "_rd_cycles"}, rdc, v.waits + 1);
    chk({tag, "_rd_bus"}, stable, 1);
    @(negedge clk);
    chk({tag, "_write"}, avm_write, v.exp_wr);
    if (v.exp_wr) begin
      chk({tag, "_wdata"}, avm_writedata, {24'd0, v.rd});
      chk({tag, "_waddr_cs"}, {avm_address, avm_chipselect, avm_read}, 3'b110);
      chk({tag, "_evt_vld"}, evt_valid, 1);
      chk({tag, "_evt_state"}, evt_state, v.exp_state);
      chk({tag, "_evt_changed"}, evt_changed, v.exp_changed);
      @(negedge clk);
    end
    chk({tag, "_vld_after"}, evt_valid, v.exp_vld);
    chk({tag, "_ovf"}, overflow, v.exp_ovf);
  endtask

  vec_t vecs[10];

  initial begin
    vec_t hv;
    bit   ok;
    int   rdc;
    int   nrd;

    vecs[0] = '{8'h00, 0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 0};
    vecs[1] = '{8'h00, 0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, POLL};
    vecs[2] = '{8'h00, 0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, POLL};
    vecs[3] = '{8'h05, 0, 1'b1, 1'b1, 8'h05, 8'h05, 1'b0, 1'b0, POLL};
    vecs[4] = '{8'h04, 0, 1'b1, 1'b1, 8'h04, 8'h01, 1'b0, 1'b0, POLL};
    vecs[5] = '{8'h84, 3, 1'b1, 1'b1, 8'h84, 8'h80, 1'b0, 1'b0, POLL};
    vecs[6] = '{8'h84, 0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, POLL};
    vecs[7] = '{8'h11, 0, 1'b0, 1'b1, 8'h11, 8'h95, 1'b1, 1'b0, POLL};
    vecs[8] = '{8'h22, 0, 1'b0, 1'b1, 8'h11, 8'h95, 1'b1, 1'b1, POLL};
    vecs[9] = '{8'h22, 0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, POLL};

    #1;
    chk("rst_read", avm_read, 0);
    chk("rst_write", avm_write, 0);
    chk("rst_cs", avm_chipselect, 0);
    chk("rst_addr", avm_address, 0);
    chk("rst_wdata", avm_writedata, 0);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_state", evt_state, 0);
    chk("rst_evt_changed", evt_changed, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_bus_error", bus_error, 0);

    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_poll(vecs[i], $sformatf("v%0d", i));
    end

    // Stuck waitrequest: read dropped after TMO cycles; clear in the abort cycle loses to the set.
    avm_readdata = 32'h77;
    wait_read(ok);
    if (ok) begin
      avm_waitrequest = 1'b1;
      rdc = 0;
      while (avm_read && rdc < 20) begin
        rdc++;
        if (rdc == TMO) clear_flags = 1'b1;
        @(negedge clk);
      end
      clear_flags = 1'b0;
      avm_waitrequest = 1'b0;
      chk("to_cycles", rdc, TMO);
      chk("to_bus_error", bus_error, 1);
      chk("to_ovf_cleared", overflow, 0);
      chk("to_no_write", avm_write, 0);
    end
    hv = '{8'h22, 0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 0};
    do_poll(hv, "post_to");
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    chk("clr_bus_error", bus_error, 0);

    // enable drops during a read: transaction finishes, then no further polls.
    evt_ready = 1'b1;
    wait_read(ok);
    if (ok) begin
      enable = 1'b0;
      avm_readdata = 32'h33;
      @(negedge clk);
      @(negedge clk);
      chk("en_write", avm_write, 1);
      chk("en_wdata", avm_writedata, 32'h33);
      nrd = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (avm_read) nrd++;
      end
      chk("en_no_reads", nrd, 0);
    end
    enable = 1'b1;

    // Reset while a write is stalled: bus drops without a clock edge.
    wait_read(ok);
    if (ok) begin
      avm_readdata = 32'h05;
      @(negedge clk);
      @(negedge clk);
      avm_waitrequest = 1'b1;
      @(negedge clk);
      chk("rw_write_held", avm_write, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rw_write_drop", avm_write, 0);
      chk("rw_cs_drop", avm_chipselect, 0);
      chk("rw_addr_drop", avm_address, 0);
      @(negedge clk);
      avm_waitrequest = 1'b0;
      rst_n = 1'b1;
    end
    hv = '{8'h05, 0, 1'b1, 1'b1, 8'h05, 8'h05, 1'b0, 1'b0, 0};
    do_poll(hv, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
